// File: rtl/vdp_vram_arb_pkg.sv
// Shared types and defaults for the VDP VRAM port arbiter.
// Requester IDs double as tag FIFO entries and grant-vector bit positions.
package vdp_vram_arb_pkg;

  typedef enum logic [1:0] {
    REQ_SCREEN = 2'd0,
    REQ_SPRITE = 2'd1,
    REQ_CPU    = 2'd2,
    REQ_CMD    = 2'd3
  } req_id_e;

  localparam int TAG_DEPTH_DEF    = 4;
  localparam int CPU_MAX_WAIT_DEF = 64;

endpackage

// File: rtl/vdp_vram_tag_fifo.sv
// Requester-ID FIFO tracking outstanding VRAM reads in issue order.
// Pointers carry an extra MSB so full and empty are distinguishable.
module vdp_vram_tag_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic [1:0]  din_i,
  input  logic        pop_i,
  output logic [1:0]  dout_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);

  logic [AW:0] wr_q, rd_q;
  logic [1:0]  mem_q [DEPTH];
  logic        do_push, do_pop;

  assign count_o = wr_q - rd_q;
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // A pop frees the head this cycle, so a push into a full FIFO is fine then
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/vdp_vram_arbiter.sv
// Four-way VRAM port arbiter: fixed priority for display fetch, round-robin
// CPU/command engine with CPU starvation override, in-order read routing.
module vdp_vram_arbiter
  import vdp_vram_arb_pkg::*;
#(
  parameter int TAG_DEPTH    = TAG_DEPTH_DEF,
  parameter int CPU_MAX_WAIT = CPU_MAX_WAIT_DEF,
  parameter int ADDR_W       = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              screen_valid,
  input  logic [ADDR_W-1:0] screen_address,
  output logic              screen_ready,
  output logic              screen_rdata_en,
  input  logic              sprite_valid,
  input  logic [ADDR_W-1:0] sprite_address,
  output logic              sprite_ready,
  output logic              sprite_rdata_en,
  input  logic              cpu_valid,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rdata_en,
  input  logic              cmd_valid,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [7:0]        cmd_wdata,
  output logic              cmd_ready,
  output logic              cmd_rdata_en,
  output logic [7:0]        rdata,
  output logic              vram_valid,
  output logic              vram_write,
  output logic [ADDR_W-1:0] vram_address,
  output logic [7:0]        vram_wdata,
  input  logic              vram_ready,
  input  logic              vram_rdata_en,
  input  logic [7:0]        vram_rdata,
  output logic              protocol_error
);

  localparam int CW = $clog2(CPU_MAX_WAIT + 1);
  localparam int FW = $clog2(TAG_DEPTH);

  logic [3:0]        vld, wr, elig, gnt;
  logic [3:0]        mask_q, rden_q;
  logic [7:0]        rdata_q;
  logic              vv_q, vw_q;
  logic [ADDR_W-1:0] va_q;
  logic [7:0]        vd_q;
  logic              perr_q, rr_q;
  logic [CW-1:0]     starve_q, starve_d;
  logic              load, ovr, can_push;
  logic              tag_push, tag_pop, tag_full, tag_empty;
  logic [1:0]        tag_id;
  logic [FW:0]       tag_cnt;
  logic              unused_cnt;
  req_id_e           win_id;
  logic              win_wr;
  logic [ADDR_W-1:0] win_addr;
  logic [7:0]        win_wdata;

  // Last cycle's winner is masked so a held request is never granted twice
  assign vld  = {cmd_valid, cpu_valid, sprite_valid, screen_valid} & ~mask_q;
  assign wr   = {cmd_write, cpu_write, 2'b00};
  assign load = !vv_q || vram_ready;
  assign ovr  = (starve_q == CW'(CPU_MAX_WAIT));

  assign tag_pop  = vram_rdata_en && !tag_empty;
  assign can_push = !tag_full || tag_pop;
  assign elig     = vld & (wr | {4{can_push}});
  assign tag_push = |(gnt & ~wr);
  assign unused_cnt = ^tag_cnt;

  always_comb begin
    gnt = '0;
    if (load && !reset) begin
      if (ovr && elig[REQ_CPU])            gnt[REQ_CPU]    = 1'b1;
      else if (elig[REQ_SCREEN])           gnt[REQ_SCREEN] = 1'b1;
      else if (elig[REQ_SPRITE])           gnt[REQ_SPRITE] = 1'b1;
      else if (elig[REQ_CPU] &&
               !(elig[REQ_CMD] && rr_q))   gnt[REQ_CPU]    = 1'b1;
      else if (elig[REQ_CMD])              gnt[REQ_CMD]    = 1'b1;
    end
  end

  always_comb begin
    win_id    = REQ_SCREEN;
    win_wr    = 1'b0;
    win_addr  = screen_address;
    win_wdata = '0;
    unique case (1'b1)
      gnt[REQ_SPRITE]: begin
        win_id   = REQ_SPRITE;
        win_addr = sprite_address;
      end
      gnt[REQ_CPU]: begin
        win_id    = REQ_CPU;
        win_wr    = cpu_write;
        win_addr  = cpu_address;
        win_wdata = cpu_wdata;
      end
      gnt[REQ_CMD]: begin
        win_id    = REQ_CMD;
        win_wr    = cmd_write;
        win_addr  = cmd_address;
        win_wdata = cmd_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!cpu_valid || gnt[REQ_CPU]) starve_d = '0;
    else if (!ovr)                  starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vv_q     <= 1'b0;
      vw_q     <= 1'b0;
      va_q     <= '0;
      vd_q     <= '0;
      mask_q   <= '0;
      rden_q   <= '0;
      rdata_q  <= '0;
      perr_q   <= 1'b0;
      rr_q     <= 1'b0;
      starve_q <= '0;
    end else begin
      if (load) begin
        vv_q <= |gnt;
        vw_q <= win_wr;
        va_q <= win_addr;
        vd_q <= win_wdata;
      end
      mask_q   <= gnt;
      starve_q <= starve_d;
      if (gnt[REQ_CPU])      rr_q <= 1'b1;
      else if (gnt[REQ_CMD]) rr_q <= 1'b0;
      rden_q <= tag_pop ? (4'b0001 << tag_id) : 4'b0000;
      if (tag_pop) rdata_q <= vram_rdata;
      if (vram_rdata_en && tag_empty) perr_q <= 1'b1;
    end
  end

  vdp_vram_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (tag_push),
    .din_i   (win_id),
    .pop_i   (tag_pop),
    .dout_o  (tag_id),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_cnt)
  );

  assign screen_ready    = gnt[REQ_SCREEN];
  assign sprite_ready    = gnt[REQ_SPRITE];
  assign cpu_ready       = gnt[REQ_CPU];
  assign cmd_ready       = gnt[REQ_CMD];
  assign screen_rdata_en = rden_q[REQ_SCREEN];
  assign sprite_rdata_en = rden_q[REQ_SPRITE];
  assign cpu_rdata_en    = rden_q[REQ_CPU];
  assign cmd_rdata_en    = rden_q[REQ_CMD];
  assign rdata           = rdata_q;
  assign vram_valid      = vv_q;
  assign vram_write      = vw_q;
  assign vram_address    = va_q;
  assign vram_wdata      = vd_q;
  assign protocol_error  = perr_q;

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Self-checking bench for vdp_vram_arbiter: queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_vdp_vram_arbiter;

  localparam int AW = 17;
  localparam int TD = 4;
  localparam int MW = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]    req_v = '0;
  logic [3:0]    req_w = '0;
  logic [AW-1:0] req_a [4];
  logic [7:0]    req_d [4];
  logic          vram_ready = 1'b0;
  logic          vram_rdata_en = 1'b0;
  logic [7:0]    vram_rdata = '0;

  logic screen_ready, sprite_ready, cpu_ready, cmd_ready;
  logic screen_rdata_en, sprite_rdata_en, cpu_rdata_en, cmd_rdata_en;
  logic [7:0] rdata, vram_wdata;
  logic vram_valid, vram_write, protocol_error;
  logic [AW-1:0] vram_address;

  vdp_vram_arbiter #(
    .TAG_DEPTH(TD), .CPU_MAX_WAIT(MW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset),
    .screen_valid(req_v[0]), .screen_address(req_a[0]),
    .screen_ready(screen_ready), .screen_rdata_en(screen_rdata_en),
    .sprite_valid(req_v[1]), .sprite_address(req_a[1]),
    .sprite_ready(sprite_ready), .sprite_rdata_en(sprite_rdata_en),
    .cpu_valid(req_v[2]), .cpu_write(req_w[2]),
    .cpu_address(req_a[2]), .cpu_wdata(req_d[2]),
    .cpu_ready(cpu_ready), .cpu_rdata_en(cpu_rdata_en),
    .cmd_valid(req_v[3]), .cmd_write(req_w[3]),
    .cmd_address(req_a[3]), .cmd_wdata(req_d[3]),
    .cmd_ready(cmd_ready), .cmd_rdata_en(cmd_rdata_en),
    .rdata(rdata),
    .vram_valid(vram_valid), .vram_write(vram_write),
    .vram_address(vram_address), .vram_wdata(vram_wdata),
    .vram_ready(vram_ready), .vram_rdata_en(vram_rdata_en),
    .vram_rdata(vram_rdata), .protocol_error(protocol_error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int            m_q[$];
  bit            m_vv, m_vw, m_perr;
  logic [AW-1:0] m_va;
  logic [7:0]    m_vd, m_rd;
  logic [3:0]    m_en, m_mask;
  int            starve, last_rr, win, last_win;
  logic [7:0]    ctrl_q[$];
  bit            auto_ctrl, rand_req;
  int            rdy_pct, ret_pct;
  logic [3:0]    seen_rdy;

  function automatic logic [3:0] rdy_vec();
    return {cmd_ready, cpu_ready, sprite_ready, screen_ready};
  endfunction

  function automatic logic [3:0] en_vec();
    return {cmd_rdata_en, cpu_rdata_en, sprite_rdata_en, screen_rdata_en};
  endfunction

  function automatic bit is_rd(int i);
    return (i < 2) || !req_w[i];
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    ctrl_q.delete();
    m_vv = 0; m_vw = 0; m_perr = 0;
    m_va = '0; m_vd = '0; m_rd = '0;
    m_en = '0; m_mask = '0;
    starve = 0; last_rr = 3; win = -1; last_win = -1;
  endtask

  // Winner from the priority list: override CPU, screen, sprite, then the
  // CPU/cmd pair ordered so whichever was not served last comes first.
  task automatic model_eval();
    bit ld, cp;
    int order[$];
    ld = !m_vv || vram_ready;
    cp = (m_q.size() < TD) || (vram_rdata_en && m_q.size() > 0);
    win = -1;
    if (ld && !reset) begin
      if (starve >= MW) order.push_back(2);
      order.push_back(0);
      order.push_back(1);
      if (last_rr == 3) begin order.push_back(2); order.push_back(3); end
      else begin order.push_back(3); order.push_back(2); end
      foreach (order[k]) begin
        int i;
        i = order[k];
        if (win < 0 && req_v[i] && !m_mask[i] && (!is_rd(i) || cp))
          win = i;
      end
    end
  endtask

  task automatic model_update();
    int id;
    m_en = '0;
    if (vram_rdata_en) begin
      if (m_q.size() > 0) begin
        id = m_q.pop_front();
        m_en[id] = 1'b1;
        m_rd = vram_rdata;
      end else m_perr = 1;
    end
    if (auto_ctrl && m_vv && vram_ready && !m_vw)
      ctrl_q.push_back(8'($urandom));
    if (!m_vv || vram_ready) begin
      m_vv = (win >= 0);
      if (win >= 0) begin
        m_vw = !is_rd(win);
        m_va = req_a[win];
        m_vd = req_d[win];
        if (is_rd(win)) m_q.push_back(win);
      end
    end
    if (req_v[2] && win != 2) starve = (starve < MW) ? starve + 1 : MW;
    else starve = 0;
    if (win == 2 || win == 3) last_rr = win;
    m_mask = '0;
    if (win >= 0) m_mask[win] = 1'b1;
    last_win = win;
  endtask

  task automatic compare();
    logic [3:0] er;
    er = (win >= 0) ? 4'(1 << win) : 4'b0;
    chk("ready", 32'(rdy_vec()), 32'(er));
    chk("vram_valid", 32'(vram_valid), 32'(m_vv));
    if (m_vv) begin
      chk("vram_write", 32'(vram_write), 32'(m_vw));
      chk("vram_address", 32'(vram_address), 32'(m_va));
      if (m_vw) chk("vram_wdata", 32'(vram_wdata), 32'(m_vd));
    end
    chk("rdata_en", 32'(en_vec()), 32'(m_en));
    if (m_en != 0) chk("rdata", 32'(rdata), 32'(m_rd));
    chk("protocol_error", 32'(protocol_error), 32'(m_perr));
  endtask

  // Called at a falling edge with inputs set; returns at the next one.
  task automatic step();
    if (auto_ctrl) begin
      vram_ready = ($urandom_range(0, 99) < rdy_pct);
      if (ctrl_q.size() > 0 && $urandom_range(0, 99) < ret_pct) begin
        vram_rdata_en = 1'b1;
        vram_rdata = ctrl_q.pop_front();
      end else begin
        vram_rdata_en = 1'b0;
        vram_rdata = 8'($urandom);
      end
    end
    if (rand_req) begin
      for (int i = 0; i < 4; i++) begin
        if (!req_v[i] || last_win == i) begin
          if ($urandom_range(0, 99) < 55) begin
            req_v[i] = 1'b1;
            req_w[i] = (i >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_a[i] = AW'($urandom);
            req_d[i] = 8'($urandom);
          end else req_v[i] = 1'b0;
        end
      end
    end
    #1;
    model_eval();
    compare();
    seen_rdy = rdy_vec();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst vram", 32'({vram_valid, vram_write, vram_wdata}), 32'(0));
    chk("rst addr", 32'(vram_address), 32'(0));
    chk("rst outs", 32'({rdata, en_vec(), rdy_vec(), protocol_error}), 32'(0));
    req_v = '0;
    req_w = '0;
    vram_ready = 1'b0;
    vram_rdata_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int sp, cp, k, k2;
    for (int i = 0; i < 4; i++) begin req_a[i] = '0; req_d[i] = '0; end
    model_reset();
    auto_ctrl = 0; rand_req = 0; rdy_pct = 100; ret_pct = 100;
    @(negedge clk);
    do_reset();

    // Screen read beats a simultaneous CPU write
    vram_ready = 1'b1;
    req_v[0] = 1'b1; req_a[0] = 17'h01800;
    req_v[2] = 1'b1; req_w[2] = 1'b1; req_a[2] = 17'h01B00; req_d[2] = 8'h32;
    step();
    chk("t1 scr first", 32'(seen_rdy), 32'(4'b0001));
    chk("t1 scr addr", 32'(vram_address), 32'(17'h01800));
    req_v[0] = 1'b0;
    step();
    chk("t1 cpu second", 32'(seen_rdy), 32'(4'b0100));
    chk("t1 cpu wdata", 32'({vram_valid, vram_write, vram_wdata}), 32'(10'h332));
    req_v[2] = 1'b0;
    step();
    step();
    chk("t1 no cpu rd", 32'(cpu_rdata_en), 32'(0));
    do_reset();

    // CPU/cmd round-robin and in-order read routing
    vram_ready = 1'b1;
    req_v[2] = 1'b1; req_w[2] = 1'b0; req_a[2] = 17'h02000;
    req_v[3] = 1'b1; req_w[3] = 1'b0; req_a[3] = 17'h03000;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2 rr grant", 32'(seen_rdy), (i % 2 == 0) ? 32'(4'b0100) : 32'(4'b1000));
    end
    req_v[2] = 1'b0; req_v[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vram_rdata_en = 1'b1;
      vram_rdata = 8'(8'hA0 + i);
      step();
      chk("t2 route", 32'(en_vec()), (i % 2 == 0) ? 32'(4'b0100) : 32'(4'b1000));
      chk("t2 rdata", 32'(rdata), 32'(8'hA0 + i));
    end
    vram_rdata_en = 1'b0;
    step();
    do_reset();

    // FIFO full stalls reads, writes still pass; a return frees a slot
    vram_ready = 1'b1;
    sp = 0; cp = 0;
    req_v[1] = 1'b1; req_a[1] = 17'h04000;
    for (int i = 0; i < 12; i++) begin
      step();
      if (seen_rdy[1]) begin sp++; req_a[1] = req_a[1] + 1'b1; end
    end
    chk("t3 four sprites", 32'(sp), 32'(4));
    req_v[2] = 1'b1; req_w[2] = 1'b1; req_a[2] = 17'h00123; req_d[2] = 8'h5C;
    for (int i = 0; i < 4; i++) begin
      step();
      if (seen_rdy[2]) begin cp++; req_v[2] = 1'b0; end
    end
    chk("t3 cpu write", 32'(cp), 32'(1));
    chk("t3 still four", 32'(sp), 32'(4));
    vram_rdata_en = 1'b1; vram_rdata = 8'h5A;
    step();
    if (seen_rdy[1]) begin sp++; req_v[1] = 1'b0; end
    vram_rdata_en = 1'b0;
    chk("t3 ret route", 32'({sprite_rdata_en, rdata}), 32'(9'h15A));
    chk("t3 fifth", 32'(sp), 32'(5));
    req_v[1] = 1'b0;
    step();
    step();
    do_reset();

    // CPU starvation override under continuous display fetch
    auto_ctrl = 1; rdy_pct = 100; ret_pct = 100;
    req_v[0] = 1'b1; req_a[0] = 17'h10000;
    req_v[1] = 1'b1; req_a[1] = 17'h11000;
    req_v[2] = 1'b1; req_w[2] = 1'b1; req_a[2] = 17'h00400; req_d[2] = 8'h11;
    k = -1;
    for (int i = 0; i < MW + 3 && k < 0; i++) begin
      step();
      if (seen_rdy[2]) k = i;
    end
    chk("t4 first wait ok", 32'(k >= 0 && k <= MW + 2), 32'(1));
    req_a[2] = 17'h00401; req_d[2] = 8'h22;
    k2 = -1;
    for (int i = 0; i < MW + 3 && k2 < 0; i++) begin
      step();
      if (seen_rdy[2]) k2 = i;
    end
    chk("t4 counter cleared", 32'(k2 >= MW - 2 && k2 <= MW + 2), 32'(1));
    req_v = '0;
    for (int i = 0; i < 4; i++) step();
    auto_ctrl = 0;
    do_reset();

    // Return with nothing outstanding
    vram_ready = 1'b1;
    vram_rdata_en = 1'b1; vram_rdata = 8'h55;
    step();
    vram_rdata_en = 1'b0;
    step();
    chk("t5 perr set", 32'(protocol_error), 32'(1));
    chk("t5 no route", 32'(en_vec()), 32'(0));
    step(); step(); step();
    chk("t5 perr sticky", 32'(protocol_error), 32'(1));
    do_reset();

    // Asynchronous reset with reads outstanding and a held slot
    vram_ready = 1'b1;
    req_v[2] = 1'b1; req_w[2] = 1'b0; req_a[2] = 17'h00100;
    req_v[3] = 1'b1; req_w[3] = 1'b0; req_a[3] = 17'h00200;
    step(); step(); step();
    req_v[2] = 1'b0; req_v[3] = 1'b0;
    vram_ready = 1'b0;
    step();
    chk("t6 slot held", 32'(vram_valid), 32'(1));
    #2 reset = 1'b1;
    #1 chk("t6 async clear", 32'({vram_valid, en_vec(), rdy_vec()}), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    vram_ready = 1'b1;
    req_v[3] = 1'b1; req_w[3] = 1'b0; req_a[3] = 17'h03800;
    step();
    chk("t6 cmd grant", 32'(seen_rdy), 32'(4'b1000));
    chk("t6 cmd addr", 32'({vram_valid, vram_address}), 32'({1'b1, 17'h03800}));
    req_v[3] = 1'b0;
    step();
    vram_rdata_en = 1'b1; vram_rdata = 8'h77;
    step();
    vram_rdata_en = 1'b0;
    chk("t6 cmd route", 32'({en_vec(), rdata}), 32'({4'b1000, 8'h77}));
    step();
    do_reset();

    // Randomised traffic: moderate, then slow returns to keep FIFO full
    auto_ctrl = 1; rand_req = 1; rdy_pct = 70; ret_pct = 45;
    for (int i = 0; i < 1500; i++) step();
    rdy_pct = 90; ret_pct = 10;
    for (int i = 0; i < 800; i++) step();
    rand_req = 0;
    req_v = '0;
    ret_pct = 100;
    for (int i = 0; i < 40; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
